// File: rtl/qpu_itcm_fetch_responder.sv
// Responder for the IFU instruction-fetch protocol in front of a 1-cycle-latency ITCM, plus host load port.
// Optional performance counters are enabled by defining QPU_ITCM_PERF_CNT_EN.
module qpu_itcm_fetch_responder #(
  parameter int          PC_W      = 32,
  parameter int          INSTR_W   = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [PC_W-1:0]    ifu_req_pc,
  input  logic               ifu_req_seq,
  output logic               ifu_rsp_valid,
  input  logic               ifu_rsp_ready,
  output logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_rsp_err,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [AW-1:0]      ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [INSTR_W-1:0] ram_wdata,
  input  logic [INSTR_W-1:0] ram_rdata
`ifdef QPU_ITCM_PERF_CNT_EN
  ,
  output logic [31:0]        perf_req_cnt,
  output logic [31:0]        perf_seq_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_err_cnt
`endif
);

  localparam logic [PC_W-1:0] BASE_PC = PC_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RSP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic               err_q;
  logic [INSTR_W-1:0] hold_q;

  logic               req_hsk;
  logic               ld_hsk;
  logic               fault;
  logic [PC_W:0]      pc_off;
  logic [PC_W-1:0]    word;
  logic [2:0]         unused_bits;

  // The extra top bit of the subtraction is the borrow, i.e. pc below the ITCM base.
  assign pc_off  = {1'b0, ifu_req_pc} - {1'b0, BASE_PC};
  assign word    = {2'b00, pc_off[PC_W-1:2]};
  assign fault   = (ifu_req_pc[1:0] != 2'b00) | pc_off[PC_W] | (word >= PC_W'(DEPTH));

  assign ifu_req_ready = (state == IDLE) | ifu_rsp_ready;
  assign req_hsk       = ifu_req_valid & ifu_req_ready;
  assign ld_ready      = ~(ifu_req_valid & ifu_req_ready);
  assign ld_hsk        = ld_valid & ld_ready;

  assign unused_bits   = {ifu_req_seq, pc_off[1:0]};

  // Fetch and load are mutually exclusive because a fetch handshake deasserts ld_ready.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (req_hsk && !fault) begin
      ram_cs   = 1'b1;
      ram_addr = word[AW-1:0];
    end else if (ld_hsk) begin
      ram_cs    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = ld_addr;
      ram_wdata = ld_data;
    end
  end

  assign ifu_rsp_valid = (state != IDLE);
  assign ifu_rsp_err   = (state != IDLE) & err_q;

  always_comb begin
    ifu_rsp_instr = '0;
    case (state)
      RSP:     ifu_rsp_instr = err_q ? '0 : ram_rdata;
      HOLD:    ifu_rsp_instr = hold_q;
      default: ifu_rsp_instr = '0;
    endcase
  end

  // A stalled RSP must snapshot the SRAM output, since a load may overwrite the array next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      err_q  <= 1'b0;
      hold_q <= '0;
    end else if (ifu_req_ready) begin
      if (req_hsk) begin
        state <= RSP;
        err_q <= fault;
      end else begin
        state <= IDLE;
        err_q <= 1'b0;
      end
    end else if (state == RSP) begin
      hold_q <= err_q ? '0 : ram_rdata;
      state  <= HOLD;
    end
  end

`ifdef QPU_ITCM_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_req_cnt   <= '0;
      perf_seq_cnt   <= '0;
      perf_stall_cnt <= '0;
      perf_err_cnt   <= '0;
    end else begin
      if (req_hsk)                        perf_req_cnt   <= sat_inc(perf_req_cnt);
      if (req_hsk && ifu_req_seq)         perf_seq_cnt   <= sat_inc(perf_seq_cnt);
      if (ifu_rsp_valid && !ifu_rsp_ready) perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (req_hsk && fault)               perf_err_cnt   <= sat_inc(perf_err_cnt);
    end
  end
`endif

endmodule

// File: doc/qpu_itcm_fetch_responder.md
Name: qpu_itcm_fetch_responder

Overview:
- Responder end of the IFU instruction-fetch protocol: accepts fetch requests (valid/ready, PC, seq flag) and returns one instruction per request on a response channel (valid/ready, instr, err).
- Fronts a single-port, 1-cycle-latency instruction SRAM (ITCM).
- Also owns a host program-load write port into the same SRAM.
- Sits between QPU IFU fetch logic and the ITCM macro.

Parameters:
- PC_W, 32, fetch address width (matches QPU PC size).
- INSTR_W, 32, instruction and SRAM data width.
- DEPTH, 1024, SRAM words; power of two.
- BASE_ADDR, 32'h0, byte address of ITCM word 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  fetch request valid
- ifu_req_ready  out  1  fetch request ready
- ifu_req_pc  in  PC_W  fetch byte address
- ifu_req_seq  in  1  sequential-fetch hint; performance counter only
- ifu_rsp_valid  out  1  response valid
- ifu_rsp_ready  in  1  response ready
- ifu_rsp_instr  out  INSTR_W  fetched instruction
- ifu_rsp_err  out  1  address fault for this response
- ld_valid  in  1  host load write valid
- ld_ready  out  1  host load write ready
- ld_addr  in  log2(DEPTH)  word index
- ld_data  in  INSTR_W  write data
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  log2(DEPTH)  SRAM word address
- ram_wdata  out  INSTR_W  SRAM write data
- ram_rdata  in  INSTR_W  SRAM read data, valid the cycle after a read cs

Behaviour:
- Reset: state=IDLE; ifu_rsp_valid=0, ifu_rsp_err=0, hold register=0, err flag=0, ram_cs=0, ram_we=0.
- The reset state keeps ifu_req_ready=1 and ld_ready=1.
- Reset mid-transaction drops any pending response; no response is issued after reset.
- FSM states:
  - IDLE: no response pending.
  - RSP: response valid, data driven directly from ram_rdata, or 0 for a fault.
  - HOLD: response valid, data driven from the hold register.
- Request acceptance:
  - ifu_req_ready = (state==IDLE) | ifu_rsp_ready. At most one outstanding response.
  - Handshake (req_hsk) = valid & ready.
- Address check on req_hsk (cycle T):
  - word = (pc - BASE_ADDR) >> 2.
  - Fault if pc[1:0]!=0, pc<BASE_ADDR, or word>=DEPTH.
  - No fault: ram_cs=1, ram_we=0, ram_addr=word[log2(DEPTH)-1:0] combinationally in T.
  - Fault: no SRAM access; err flag registered.
- Latency: ifu_rsp_valid rises in T+1; state becomes RSP.
  - ifu_rsp_instr = ram_rdata when no fault; 0 when fault. ifu_rsp_err = registered err flag.
- RSP with ifu_rsp_ready=0:
  - Capture ram_rdata (or 0) and err into the hold register in that cycle; go to HOLD.
  - Outputs stay stable until accepted.
- RSP/HOLD with ifu_rsp_ready=1:
  - Response retires.
  - A new req_hsk in the same cycle goes to RSP next cycle (back-to-back throughput 1/cycle); otherwise go to IDLE.
- Simultaneous events:
  - A retire and a new request in the same cycle is legal. SRAM output is consumed before being overwritten.
  - Load vs fetch: fetch has priority. ld_ready = ~(ifu_req_valid & ifu_req_ready).
  - On ld handshake: ram_cs=1, ram_we=1, ram_addr=ld_addr, ram_wdata=ld_data.
  - A load never disturbs a pending response: ram_rdata is captured in RSP before a write can occur, because a write only happens in a cycle with no read cs.
- ram_cs/ram_we/ram_addr/ram_wdata are combinational. ram_we=0 whenever ram_cs=0; addr/wdata are 0 when idle.
- ifu_rsp_valid never drops without a handshake, except on reset.
- ifu_req_seq has no functional effect.

Optional Feature:
- Macro: QPU_ITCM_PERF_CNT_EN.
- When defined, adds these outputs:
  - perf_req_cnt[31:0]: req handshakes.
  - perf_seq_cnt[31:0]: handshakes with seq=1.
  - perf_stall_cnt[31:0]: cycles with ifu_rsp_valid & ~ifu_rsp_ready.
  - perf_err_cnt[31:0]: fault responses.
- Counter rules: reset to 0, saturate at 32'hFFFF_FFFF, no wrap.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Preload word 3=32'hDEAD_BEEF via ld port; fetch pc=32'hC with rsp_ready=1 -> ifu_rsp_valid in T+1, instr=32'hDEAD_BEEF, err=0.
- Fetch pc=0x0,0x4,0x8 back-to-back with ready held 1 (words 0x11,0x22,0x33) -> three responses in consecutive cycles, req_ready stays 1.
- Fetch pc=0x4 with rsp_ready=0 for 5 cycles -> valid held, instr stable at 0x22 from HOLD, req_ready=0; accepted on cycle 6.
- Fetch pc=0x6 and pc=4*DEPTH -> err=1, instr=0, ram_cs never asserted.
- ld_valid and ifu_req_valid together while IDLE -> ld_ready=0, fetch wins; load completes next cycle, read data of the pending response unaffected.
- Assert rst while in HOLD -> ifu_rsp_valid=0 immediately, state IDLE; next fetch of 0x0 returns 0x11 normally.
